ycc_block_buffer: RTL and testbench



---
 rtl/jpeg_pkg.sv | 18 +
 rtl/ycc_bank_ram.sv | 22 ++
 rtl/ycc_block_buffer.sv | 136 +++++++++++++
 tb/tb_ycc_block_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and read-FSM encoding for the JPEG front-end blocks.
package jpeg_pkg;

  localparam int BLK_PIXELS = 64;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam int LVL_SHIFT = 128;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_PREFETCH = 2'd1,
    RD_STREAM   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ycc_bank_ram.sv
// 128-entry simple dual-port synchronous RAM; address MSB selects the ping-pong bank.
module ycc_bank_ram #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         we,
  input  logic [6:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [6:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [0:127];

  // rdata holds while re is low so a stalled output sample stays stable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ycc_block_buffer.sv
// Ping-pong 8x8 block buffer replaying each block as Y, Cb, Cr planes.
// Define LEVEL_SHIFT_EN to emit samples level-shifted by -128 for the DCT.
module ycc_block_buffer #(
  parameter int DATA_W     = 8,
  parameter int BLK_PIXELS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Y,
  input  logic [DATA_W-1:0] Cb,
  input  logic [DATA_W-1:0] Cr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_comp,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              blk_done
);
  import jpeg_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(BLK_PIXELS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready never depends combinationally on valid on either side.

  rd_state_t           state, state_nx;
  logic [1:0]          bank_full, bank_full_nx;
  logic                wr_bank, rd_bank;
  logic [5:0]          wr_idx, rd_idx, rd_addr_idx;
  logic [1:0]          rd_comp;
  logic                ren;
  logic [3*DATA_W-1:0] ram_q;
  logic [DATA_W-1:0]   sample, sample_out;
  logic                in_fire, out_fire, last_fire;

  assign in_ready  = !bank_full[wr_bank];
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == RD_STREAM);
  assign out_fire  = out_valid && out_ready;
  assign last_fire = out_fire && (rd_comp == COMP_CR) && (rd_idx == LAST_IDX);

  ycc_bank_ram #(.W(3*DATA_W)) u_ram (
    .clk   (clk),
    .we    (in_fire),
    .waddr ({wr_bank, wr_idx}),
    .wdata ({Y, Cb, Cr}),
    .re    (ren),
    .raddr ({rd_bank, rd_addr_idx}),
    .rdata (ram_q)
  );

  // The RAM word carries all three components, so the read address only
  // follows the raster index; rd_bank has already toggled on entry to PREFETCH.
  always_comb begin
    state_nx    = state;
    ren         = 1'b0;
    rd_addr_idx = rd_idx + 6'd1;
    case (state)
      RD_IDLE: begin
        if (bank_full[rd_bank]) state_nx = RD_PREFETCH;
      end
      RD_PREFETCH: begin
        ren         = 1'b1;
        rd_addr_idx = 6'd0;
        state_nx    = RD_STREAM;
      end
      RD_STREAM: begin
        if (last_fire) begin
          state_nx = bank_full[!rd_bank] ? RD_PREFETCH : RD_IDLE;
        end else if (out_fire) begin
          ren = 1'b1;
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    bank_full_nx = bank_full;
    if (last_fire) bank_full_nx[rd_bank] = 1'b0;
    if (in_fire && (wr_idx == LAST_IDX)) bank_full_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_IDLE;
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= 6'd0;
      rd_idx    <= 6'd0;
      rd_comp   <= COMP_Y;
      blk_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      bank_full <= bank_full_nx;
      blk_done  <= last_fire;
      if (in_fire) begin
        wr_idx <= wr_idx + 6'd1;
        if (wr_idx == LAST_IDX) wr_bank <= !wr_bank;
      end
      if (last_fire) begin
        rd_bank <= !rd_bank;
        rd_idx  <= 6'd0;
        rd_comp <= COMP_Y;
      end else if (out_fire) begin
        rd_idx <= rd_idx + 6'd1;
        if (rd_idx == LAST_IDX) rd_comp <= rd_comp + 2'd1;
      end
    end
  end

  always_comb begin
    case (rd_comp)
      COMP_Y:  sample = ram_q[3*DATA_W-1:2*DATA_W];
      COMP_CB: sample = ram_q[2*DATA_W-1:DATA_W];
      default: sample = ram_q[DATA_W-1:0];
    endcase
  end

`ifdef LEVEL_SHIFT_EN
  assign sample_out = sample - DATA_W'(LVL_SHIFT);
`else
  assign sample_out = sample;
`endif

  // RAM output is not reset, so gate data to zero whenever nothing is presented.
  assign out_data = out_valid ? sample_out : '0;
  assign out_comp = rd_comp;
  assign out_idx  = rd_idx;
  assign out_last = out_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_ycc_block_buffer.sv
// Scoreboard bench for ycc_block_buffer: directed blocks, stalls, random backpressure, mid-stream reset.
module tb_ycc_block_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Y, Cb, Cr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_comp;
  logic [5:0] out_idx;
  logic       out_last;
  logic       blk_done;

  int checks = 0;
  int failures = 0;
  int blk_seen = 0;
  int blk_exp = 0;
  logic rand_done;

  // {comp, idx, last, data}
  logic [16:0] exp_q[$];

  ycc_block_buffer #(.DATA_W(8), .BLK_PIXELS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .Cb        (Cb),
    .Cr        (Cr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_comp  (out_comp),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .blk_done  (blk_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] exp_val(input logic [7:0] raw);
`ifdef LEVEL_SHIFT_EN
    exp_val = {~raw[7], raw[6:0]};
`else
    exp_val = raw;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        stall_prev = 1'b0;
  logic [16:0] held;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (stall_prev)
          check("hold_stable", {15'd0, out_comp, out_idx, out_last, out_data}, {15'd0, held});
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_sample", {15'd0, out_comp, out_idx, out_last, out_data}, 32'hFFFF_FFFF);
          end else begin
            held = exp_q.pop_front();
            check("sample", {15'd0, out_comp, out_idx, out_last, out_data}, {15'd0, held});
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held = {out_comp, out_idx, out_last, out_data};
        end
      end else begin
        stall_prev = 1'b0;
      end
      if (blk_done) blk_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; Y = y; Cb = cb; Cr = cr;
    while (!in_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_block(input int kind, input int b);
    logic [7:0] py[64];
    logic [7:0] pc[64];
    logic [7:0] pr[64];
    logic [7:0] raw;
    for (int k = 0; k < 64; k++) begin
      case (kind)
        0: begin py[k] = 8'd128; pc[k] = 8'd128; pr[k] = 8'd128; end
        1: begin py[k] = 8'd76;  pc[k] = 8'd85;  pr[k] = 8'd255; end
        2: begin py[k] = 8'(k); pc[k] = 8'(64 + k); pr[k] = 8'(255 - k); end
        default: begin
          py[k] = 8'(k * 5 + b * 17);
          pc[k] = 8'(k * 3 + b + 1);
          pr[k] = 8'(255 - 2 * k - b);
        end
      endcase
    end
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 64; i++) begin
        raw = (c == 0) ? py[i] : (c == 1) ? pc[i] : pr[i];
        exp_q.push_back({2'(c), 6'(i), (i == 63), exp_val(raw)});
      end
    end
    for (int k = 0; k < 64; k++) send_pixel(py[k], pc[k], pr[k]);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 10000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 10000) check("drain_timeout", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_blk_done(output int cycles);
    cycles = 0;
    while (!blk_done && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles >= 1000) check("blk_done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; Y = 8'd0; Cb = 8'd0; Cr = 8'd0; out_ready = 1'b0;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_comp",  out_comp,  0);
    check("rst_out_idx",   out_idx,   0);
    check("rst_out_last",  out_last,  0);
    check("rst_blk_done",  blk_done,  0);
    rst = 1'b0;

    // Gray block: latency and gap-free streaming
    out_ready = 1'b1;
    send_block(0, 0); blk_exp++;
    check("lat_edge0", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2", out_valid, 1);
    wait_blk_done(cnt);
    check("stream_cycles", cnt, 192);
    wait_drain();

    // Converted red, then ramp
    send_block(1, 0); blk_exp++;
    wait_drain();
    send_block(2, 0); blk_exp++;
    wait_drain();

    // Stall: fill both banks, extra pixel refused
    out_ready = 1'b0;
    send_block(3, 0); blk_exp++;
    check("in_ready_after_64", in_ready, 1);
    send_block(3, 1); blk_exp++;
    check("in_ready_after_128", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b1; Y = 8'hAA; Cb = 8'hBB; Cr = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("px129_refused", in_ready, 0);
    end
    in_valid = 1'b0;
    check("stall_valid", out_valid, 1);
    check("stall_idx", {out_comp, out_idx}, 8'd0);
    out_ready = 1'b1;
    wait_blk_done(cnt);
    check("bubble_low", out_valid, 0);
    @(posedge clk); #1;
    check("bubble_resume", out_valid, 1);
    wait_drain();

    // Random backpressure over four blocks
    fork
      begin
        for (int b = 2; b < 6; b++) begin
          send_block(3, b); blk_exp++;
        end
        wait_drain();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    check("blk_count_mid", blk_seen, blk_exp);

    // Reset at sample 100 of a block
    send_block(2, 0);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("rst_test_start", out_valid, 1);
    repeat (100) @(posedge clk);
    #1;
    check("rst_test_idx", out_idx, 100 - 64);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    send_block(3, 6); blk_exp++;
    wait_drain();

    check("blk_count", blk_seen, blk_exp);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
